pattern_eval_scheduler: RTL and testbench
=========================================

// Module: pattern_eval_scheduler
// PURPOSE
//   Shares one merged-pattern evaluation datapath (11-bit IN vector -> 8-bit result,
//   fixed pipeline latency) between NREQ requesters.
//   Round-robin arbitration, issue/wait/capture sequencing, one transaction in flight.
//   Sits between the pattern-engine front ends and the merged-graph netlist instance.
// PARAMETERS
//   NREQ   4   number of requesters (2..8)
//   IN_W   11  datapath input vector width
//   OUT_W  8   datapath result width
//   LAT    2   datapath latency: result valid LAT cycles after dp_valid (1..15)
// PORTS
//   blif_clk_net    in   1            single clock, rising edge
//   blif_reset_net  in   1            asynchronous, active-low reset
//   sched_en        in   1            1 = new grants allowed; 0 = drain only
//   req_valid       in   NREQ         per-requester request
//   req_data        in   NREQ*IN_W    request vectors; slice i belongs to requester i
//   req_ready       out  NREQ         one-hot 1-cycle accept pulse
//   dp_in           out  IN_W         vector driven to datapath; held stable from ISSUE to DONE
//   dp_valid        out  1            1-cycle issue strobe to datapath
//   dp_result       in   OUT_W        datapath result; sampled in DONE
//   rsp_valid       out  NREQ         one-hot 1-cycle response pulse to the granted requester
//   rsp_data        out  OUT_W        captured result; held until next capture
//   gnt_id          out  3            index of the current/last grant
//   busy            out  1            1 in ISSUE, WAIT and DONE
// BEHAVIOUR
//   Reset (async, blif_reset_net=0): all outputs 0; FSM=IDLE; wait counter=0;
//     last_grant=NREQ-1, so requester 0 wins the first arbitration.
//   FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   - IDLE: if sched_en && |req_valid, choose the first valid requester searching
//     from last_grant+1 (mod NREQ). In the same cycle:
//     - req_ready[g]=1 (combinational from registered state plus inputs);
//     - dp_in <= req_data[g] and gnt_id <= g on the clock edge;
//     - next state = ISSUE.
//   - ISSUE (cycle t): dp_valid=1; counter <= LAT-1. If LAT==1 go to DONE,
//     else go to WAIT.
//   - WAIT: decrement counter; move to DONE when counter reaches 1.
//     DONE is therefore at cycle t+LAT.
//   - DONE (t+LAT): rsp_data <= dp_result; rsp_valid[gnt_id] <= 1 for cycle t+LAT+1;
//     last_grant <= gnt_id; next state = IDLE.
//   - Back-to-back: IDLE at t+LAT+1 may grant in that same cycle (rsp_valid and
//     req_ready may coincide). Minimum period per transaction = LAT+2 cycles.
//   - req_valid dropping after a grant has no effect; the transaction completes.
//   - sched_en=0 mid-transaction: the in-flight transaction completes normally;
//     no new grant is made while sched_en=0.
//   - Only the requester granted last is skipped on the next search. A single
//     requester holding req_valid high is re-granted every LAT+2 cycles.
//   - Async reset mid-transaction: aborts immediately; no rsp_valid is emitted;
//     the datapath result is discarded.
//   - Index arithmetic is mod NREQ; gnt_id is zero-extended to 3 bits.
// CONFIGURATION
//   PATTERN_SCHED_PRIO_EN defined:
//     - requester 0 has absolute priority: if req_valid[0] in IDLE it is granted
//       regardless of last_grant;
//     - others use round-robin among 1..NREQ-1 with their own pointer.
//   Not defined: pure round-robin over all NREQ as above.
// TESTING
//   1) Reset with all req_valid=1 (LAT=2, NREQ=4).
//      -> grant order 0,1,2,3,0; req_ready pulses every 4 cycles.
//   2) req_valid=4'b0100, req_data[2]=11'h5A3; model result = 8'hC7.
//      -> dp_valid 1 cycle after req_ready; dp_in=11'h5A3;
//         rsp_valid=4'b0100 and rsp_data=8'hC7 exactly 3 cycles after dp_valid.
//   3) Drop sched_en during WAIT with req_valid=4'b1111.
//      -> current rsp_valid still fires; no req_ready until sched_en returns to 1.
//   4) Assert blif_reset_net=0 during WAIT.
//      -> busy, dp_valid and rsp_valid go 0 at once; no response;
//         first grant after release = requester 0.
//   5) LAT=1 build, requester 3 only.
//      -> req_ready[3] every 3 cycles; rsp_valid coincides with the next req_ready[3].
//   6) PATTERN_SCHED_PRIO_EN, req_valid=4'b0011 held.
//      -> requester 0 granted every transaction; requester 1 never granted.
//      Without the macro: grants alternate 0,1.

Source files
------------

// File: rtl/pattern_eval_scheduler.sv
// Purpose : round-robin scheduler sharing one fixed-latency pattern-evaluation datapath between NREQ requesters.
// Latency : req_ready -> dp_valid 1 cycle; dp_valid -> rsp_valid LAT+1 cycles; one grant every LAT+2 cycles at best.
// Backpres: one transaction in flight; requesters hold req_valid until their 1-cycle req_ready; sched_en=0 only blocks new grants.
//
// Ports
//   blif_clk_net / blif_reset_net : clock (rising edge) / async active-low reset
//   sched_en                       : 1 allows new grants, 0 drains the in-flight transaction only
//   req_valid, req_data, req_ready : per-requester request, vector slice i, one-hot accept pulse
//   dp_in, dp_valid, dp_result     : datapath vector (held ISSUE..DONE), issue strobe, result sampled in DONE
//   rsp_valid, rsp_data            : one-hot response pulse, captured result held until next capture
//   gnt_id, busy                   : current/last grant index, transaction in progress
//
// Build option: define PATTERN_SCHED_PRIO_EN to give requester 0 absolute priority,
// with round-robin among requesters 1..NREQ-1 on their own pointer.

module pattern_eval_scheduler #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int LAT   = 2
) (
    input  logic                   blif_clk_net,
    input  logic                   blif_reset_net,
    input  logic                   sched_en,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*IN_W-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [IN_W-1:0]        dp_in,
    output logic                   dp_valid,
    input  logic [OUT_W-1:0]       dp_result,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [OUT_W-1:0]       rsp_data,
    output logic [2:0]             gnt_id,
    output logic                   busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [2:0]      last_grant;   // round-robin pointer; in priority builds it tracks requesters 1..NREQ-1 only
    logic [IW-1:0]   cand;
    logic            found;
    logic [2:0]      pick;
    logic [NREQ-1:0] grant_oh;
    logic [IN_W-1:0] sel_data;
    logic            do_grant;

    // Search starts one past the last grant so only that requester is skipped.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        cand  = '0;
`ifdef PATTERN_SCHED_PRIO_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k < NREQ; k++) begin
            // ring of size NREQ-1 over indices 1..NREQ-1
            cand = IW'(1 + ((int'(last_grant) - 1 + k) % (NREQ - 1)));
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = 3'(cand);
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = 3'(cand);
            end
        end
`endif
    end

    always_comb begin
        grant_oh = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (found && pick == 3'(i)) begin
                grant_oh[i] = 1'b1;
                sel_data    = req_data[i*IN_W +: IN_W];
            end
        end
    end

    // Gated by reset so req_ready is also low while reset is asserted.
    assign do_grant  = (state == S_IDLE) && sched_en && found && blif_reset_net;
    assign req_ready = do_grant ? grant_oh : '0;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            last_grant <= 3'(NREQ - 1);
            dp_in      <= '0;
            dp_valid   <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            gnt_id     <= 3'd0;
            busy       <= 1'b0;
        end else begin
            dp_valid  <= 1'b0;
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (do_grant) begin
                        dp_in    <= sel_data;
                        gnt_id   <= pick;
                        dp_valid <= 1'b1;   // high during ISSUE
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= 4'(LAT - 1);
                    state <= (LAT == 1) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    rsp_data  <= dp_result;
                    rsp_valid <= NREQ'(1) << gnt_id;
`ifdef PATTERN_SCHED_PRIO_EN
                    if (gnt_id != 3'd0) begin
                        last_grant <= gnt_id;
                    end
`else
                    last_grant <= gnt_id;
`endif
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_eval_scheduler.sv
// Purpose : self-checking bench for pattern_eval_scheduler (LAT=2 main instance, LAT=1 second instance).
// Latency : datapath models return f(dp_in) LAT cycles after dp_valid; responses expected LAT+2 cycles after grant.
// Backpres: a per-cycle model predicts req_ready; expected responses are queued at grant and popped on rsp_valid.

module tb_pattern_eval_scheduler;

    localparam int NREQ  = 4;
    localparam int IN_W  = 11;
    localparam int OUT_W = 8;
    localparam int LAT   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sched_en = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*IN_W-1:0] req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic [IN_W-1:0]      dp_in;
    logic                 dp_valid;
    logic [OUT_W-1:0]     dp_result;
    logic [NREQ-1:0]      rsp_valid;
    logic [OUT_W-1:0]     rsp_data;
    logic [2:0]           gnt_id;
    logic                 busy;

    logic [NREQ-1:0]      l1_req_valid = '0;
    logic [NREQ*IN_W-1:0] l1_req_data = '0;
    logic [NREQ-1:0]      l1_req_ready;
    logic [IN_W-1:0]      l1_dp_in;
    logic                 l1_dp_valid;
    logic [OUT_W-1:0]     l1_dp_result;
    logic [NREQ-1:0]      l1_rsp_valid;
    logic [OUT_W-1:0]     l1_rsp_data;
    logic [2:0]           l1_gnt_id;
    logic                 l1_busy;

    always #5 clk = ~clk;

    pattern_eval_scheduler #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT)) dut (
        .blif_clk_net(clk), .blif_reset_net(rst_n), .sched_en(sched_en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .dp_in(dp_in), .dp_valid(dp_valid), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .gnt_id(gnt_id), .busy(busy));

    pattern_eval_scheduler #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT(1)) dut_l1 (
        .blif_clk_net(clk), .blif_reset_net(rst_n), .sched_en(1'b1),
        .req_valid(l1_req_valid), .req_data(l1_req_data), .req_ready(l1_req_ready),
        .dp_in(l1_dp_in), .dp_valid(l1_dp_valid), .dp_result(l1_dp_result),
        .rsp_valid(l1_rsp_valid), .rsp_data(l1_rsp_data), .gnt_id(l1_gnt_id), .busy(l1_busy));

    // Datapath function: f(11'h5A3) = 8'hC7, f(11'h123) = 8'h37.
    function automatic logic [7:0] dp_func(input logic [10:0] x);
        return x[7:0] + {3'b000, x[10:8], 2'b00} + 8'h10;
    endfunction

    // Datapath models; results are zero unless launched by dp_valid, so a mistimed capture is visible.
    logic [7:0] pipe [LAT];
    logic [7:0] l1_pipe;
    always @(posedge clk) begin
        pipe[0] <= dp_valid ? dp_func(dp_in) : 8'h00;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        l1_pipe <= l1_dp_valid ? dp_func(l1_dp_in) : 8'h00;
    end
    assign dp_result    = pipe[LAT-1];
    assign l1_dp_result = l1_pipe;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] res;
        int         due;
    } exp_t;

    exp_t        sb[$];
    int          g_log[$];
    int          cyc = 0;
    int          m_free = 0;
    int          m_issue = -1;
    int          m_last = NREQ - 1;
    int          m_hi = NREQ - 1;
    logic [10:0] m_din = '0;
    int          m_gnt = 0;

    function automatic int pick_model(input logic [3:0] v);
`ifdef PATTERN_SCHED_PRIO_EN
        if (v[0]) return 0;
        for (int k = 1; k < NREQ; k++) begin
            int c;
            c = 1 + ((m_hi - 1 + k) % (NREQ - 1));
            if (v[c]) return c;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (v[c]) return c;
        end
`endif
        return 0;
    endfunction

    // Per-cycle model of the main instance, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_out", {busy, dp_valid, rsp_valid, rsp_data, gnt_id, dp_in, req_ready,
                            l1_busy, l1_dp_valid, l1_rsp_valid, l1_req_ready}, 64'd0);
            sb.delete();
            m_free  = 0;
            m_issue = -1;
            m_last  = NREQ - 1;
            m_hi    = NREQ - 1;
        end else begin
            logic [3:0] exp_rdy;
            int         g;
            exp_rdy = 4'd0;
            g = 0;
            if (cyc >= m_free && sched_en && (|req_valid)) begin
                g = pick_model(req_valid);
                exp_rdy = 4'd1 << g;
            end
            chk("req_ready", req_ready, exp_rdy);
            if (exp_rdy != 4'd0) begin
                sb.push_back('{g, dp_func(req_data[g*IN_W +: IN_W]), cyc + LAT + 2});
                m_free  = cyc + LAT + 2;
                m_issue = cyc + 1;
                m_din   = req_data[g*IN_W +: IN_W];
                m_gnt   = g;
                m_last  = g;
                if (g != 0) m_hi = g;
                g_log.push_back(g);
            end
            chk("dp_valid", dp_valid, cyc == m_issue);
            if (cyc == m_issue) begin
                chk("dp_in", dp_in, m_din);
                chk("gnt_id", gnt_id, m_gnt);
            end
            chk("busy", busy, (cyc >= m_free - LAT - 1) && (cyc < m_free));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("rsp_valid", rsp_valid, 4'd1 << sb[0].id);
                chk("rsp_data", rsp_data, sb[0].res);
                void'(sb.pop_front());
            end else begin
                chk("rsp_idle", rsp_valid, 4'd0);
            end
        end
    end

    // Bounded wait on falling edges: 0 = dp_valid, 1 = rsp_valid, 2 = l1 req_ready[3].
    task automatic wait_for(input int which, output int n);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if ((which == 0 && dp_valid) || (which == 1 && rsp_valid != '0) ||
                (which == 2 && l1_req_ready[3])) return;
        end
        chk("wait_timeout", n, which);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int n, nr, ng;
        int exp_ord [5];
`ifdef PATTERN_SCHED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        // 1) reset with all requesters active
        sched_en  = 1'b1;
        req_valid = 4'b1111;
        req_data  = {11'h444, 11'h333, 11'h222, 11'h111};
        rst_n     = 1'b0;
        step(3);
        g_log.delete();
        rst_n = 1'b1;
        step(20);
        if (g_log.size() < 5) chk("t1_count", g_log.size(), 5);
        else for (int i = 0; i < 5; i++) chk("t1_order", g_log[i], exp_ord[i]);

        // 2) single requester 2 with a known vector
        req_valid = 4'b0000;
        step(6);
        req_data[2*IN_W +: IN_W] = 11'h5A3;
        req_valid = 4'b0100;
        wait_for(0, n);
        chk("t2_dp_in", dp_in, 11'h5A3);
        wait_for(1, n);
        chk("t2_latency", n, 3);
        chk("t2_rsp_valid", rsp_valid, 4'b0100);
        chk("t2_rsp_data", rsp_data, 8'hC7);
        step(1);
        req_valid = 4'b0000;
        step(6);

        // 3) sched_en dropped during WAIT
        req_valid = 4'b1111;
        wait_for(0, n);
        step(1);
        sched_en = 1'b0;
        nr = 0;
        ng = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid != '0) nr++;
            if (req_ready != '0) ng++;
        end
        chk("t3_rsp_count", nr, 1);
        chk("t3_no_ready", ng, 0);
        step(1);
        sched_en = 1'b1;
        step(8);

        // 4) reset asserted during WAIT
        wait_for(0, n);
        step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", busy, 1'b0);
        chk("t4_dp_valid", dp_valid, 1'b0);
        chk("t4_rsp_valid", rsp_valid, 4'b0000);
        g_log.delete();
        step(1);
        rst_n = 1'b1;
        step(10);
        if (g_log.size() < 1) chk("t4_count", g_log.size(), 1);
        else chk("t4_first_grant", g_log[0], 0);

        // 5) LAT=1 instance, requester 3 only
        l1_req_data[3*IN_W +: IN_W] = 11'h123;
        l1_req_valid = 4'b1000;
        wait_for(2, n);
        for (int p = 0; p < 4; p++) begin
            wait_for(2, n);
            chk("t5_period", n, 3);
            chk("t5_rsp_valid", l1_rsp_valid, 4'b1000);
            chk("t5_rsp_data", l1_rsp_data, 8'h37);
        end
        step(1);
        l1_req_valid = 4'b0000;

        // 6) requesters 0 and 1 held after a fresh reset
        req_valid = 4'b0000;
        step(6);
        rst_n = 1'b0;
        step(2);
        g_log.delete();
        req_valid = 4'b0011;
        rst_n = 1'b1;
        step(24);
        if (g_log.size() < 4) chk("t6_count", g_log.size(), 4);
        else for (int i = 0; i < g_log.size(); i++) begin
`ifdef PATTERN_SCHED_PRIO_EN
            chk("t6_prio_grant", g_log[i], 0);
`else
            chk("t6_rr_grant", g_log[i], i % 2);
`endif
        end
        req_valid = 4'b0000;
        step(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
